screen_scanout: RTL and testbench

Display-side reader for the Hack screen memory map. It walks the 512×256 monochrome frame buffer in raster order through a synchronous read port (8192 words, 32 words per row) and serialises each word into a pixel stream. It also generates data-enable, horizontal sync, vertical sync and frame-start timing. It sits between the screen RAM's second (display) read port and the video output pins; the CPU keeps writing the screen through the memory map.

---
 rtl/hack_screen_pkg.sv | 17 +
 rtl/screen_scanout_if.sv | 16 +
 rtl/screen_scanout_timing.sv | 110 +++++++++++
 rtl/screen_scanout.sv | 121 ++++++++++++
 tb/tb_screen_scanout.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_screen_pkg.sv
// Shared constants for the Hack screen memory map.
// The frame buffer is 512x256 monochrome pixels, stored as 8192 16-bit words
// with 32 words per row. The CPU sees it at SCREEN_BASE; the display side
// addresses it with a 13-bit word index.
package hack_screen_pkg;

  localparam int unsigned SCREEN_W      = 512;
  localparam int unsigned SCREEN_H      = 256;
  localparam int unsigned WORDS_PER_ROW = 32;
  localparam int unsigned SCREEN_WORDS  = 8192;
  localparam logic [14:0] SCREEN_BASE   = 15'h4000;
  localparam int unsigned ADDR_W        = 13;

  typedef logic [ADDR_W-1:0] scr_addr_t;
  typedef logic [15:0]       scr_word_t;

endpackage

// File: rtl/screen_scanout_if.sv
// Display read port of the screen RAM.
//   rd_en   : one-clk read request
//   rd_addr : word address (0..8191)
//   rd_data : read data, valid exactly one clk after rd_en
// master = scanout side (issues reads), slave = RAM side (returns data).
interface screen_scanout_if;
  import hack_screen_pkg::*;

  logic      rd_en;
  scr_addr_t rd_addr;
  scr_word_t rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/screen_scanout_timing.sv
// screen_timing: raster counters and video timing decode.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   pix_ce       : pixel tick; counters and registered outputs advance only on it
//   active       : current (h,v) lies in the visible 512x256 area (combinational)
//   load         : current h is the first pixel of a word (h%16 == 0)
//   fetch        : this tick must issue a screen read (tick-qualified)
//   de, hsync, vsync, frame_start : registered timing outputs
module screen_timing
  import hack_screen_pkg::*;
#(
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_ce,
  output logic active,
  output logic load,
  output logic fetch,
  output logic de,
  output logic hsync,
  output logic vsync,
  output logic frame_start
);

  localparam int unsigned H_TOTAL = SCREEN_W + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = SCREEN_H + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FETCH0 = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_ACT    = HW'(SCREEN_W);
  localparam logic [HW-1:0] H_WEND   = HW'(SCREEN_W - 16);
  localparam logic [HW-1:0] HS_BEG   = HW'(SCREEN_W + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(SCREEN_W + H_FRONT + H_SYNC);

  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(SCREEN_H);
  localparam logic [VW-1:0] V_LASTROW = VW'(SCREEN_H - 1);
  localparam logic [VW-1:0] VS_BEG    = VW'(SCREEN_H + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(SCREEN_H + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  logic in_row, hs_act, vs_act, fetch_pos;

  assign in_row = v_q < V_ACT;
  assign active = (h_q < H_ACT) && in_row;
  assign load   = h_q[3:0] == 4'd0;
  assign hs_act = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act = (v_q >= VS_BEG) && (v_q < VS_END);

  // Words 1..31 of a row are fetched two ticks before their first pixel; word 0
  // is fetched at the end of the previous line (line V_TOTAL-1 for row 0).
  assign fetch_pos = (in_row && (h_q[3:0] == 4'd14) && (h_q < H_WEND)) ||
                     ((h_q == H_FETCH0) && ((v_q < V_LASTROW) || (v_q == V_LAST)));
  assign fetch     = pix_ce && fetch_pos;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    fs_d    = 1'b0;
    if (pix_ce) begin
      de_d    = active;
      hsync_d = hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_d = vs_act ? SYNC_POL : ~SYNC_POL;
      fs_d    = (h_q == '0) && (v_q == '0);
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= V_ACT;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/screen_scanout.sv
// screen_scanout: raster reader for the Hack screen frame buffer.
// Walks the 512x256 screen in raster order through the display read port,
// serialises each 16-bit word LSB-first into a pixel stream and emits
// de/hsync/vsync/frame_start timing.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   pix_ce      : pixel tick enable
//   rd          : screen RAM read port (rd_en, rd_addr, rd_data)
//   pixel       : 1 = black, 0 outside active video
//   de, hsync, vsync, frame_start : video timing outputs
module screen_scanout
  import hack_screen_pkg::*;
#(
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_ce,
  screen_scanout_if.master         rd,
  output logic                     pixel,
  output logic                     de,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start
);

  logic active, load, fetch;

  screen_timing #(
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .active      (active),
    .load        (load),
    .fetch       (fetch),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  logic      rd_en_q, rd_en_d;
  scr_addr_t rd_addr_q, rd_addr_d;
  scr_addr_t next_addr_q, next_addr_d;
  logic      cap_q, cap_d;
  scr_word_t pbuf_q, pbuf_d;
  scr_word_t shift_q, shift_d;
  logic      pixel_q, pixel_d;

  always_comb begin
    rd_en_d     = fetch;
    rd_addr_d   = rd_addr_q;
    next_addr_d = next_addr_q;
    // Fetches always come in raster order, so a wrapping word counter
    // supplies the address; reset realigns it with the timing counters.
    if (fetch) begin
      rd_addr_d   = next_addr_q;
      next_addr_d = next_addr_q + 1'b1;
    end

    // rd_data returns the clk after the RAM sees rd_en; capture regardless of pix_ce.
    cap_d  = rd_en_q;
    pbuf_d = cap_q ? rd.rd_data : pbuf_q;

    shift_d = shift_q;
    pixel_d = pixel_q;
    if (pix_ce) begin
      if (active) begin
        if (load) begin
          // pbuf_d bypasses the capture so a word returning on this very
          // clk (pix_ce tied high) is used at its first pixel.
          pixel_d = pbuf_d[0];
          shift_d = pbuf_d >> 1;
        end else begin
          pixel_d = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end else begin
        pixel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      next_addr_q <= '0;
      cap_q       <= 1'b0;
      pbuf_q      <= '0;
      shift_q     <= '0;
      pixel_q     <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      next_addr_q <= next_addr_d;
      cap_q       <= cap_d;
      pbuf_q      <= pbuf_d;
      shift_q     <= shift_d;
      pixel_q     <= pixel_d;
    end
  end

  assign rd.rd_en   = rd_en_q;
  assign rd.rd_addr = rd_addr_q;
  assign pixel      = pixel_q;

endmodule

// File: tb/tb_screen_scanout.sv
module tb_screen_scanout;
  import hack_screen_pkg::*;

  localparam int unsigned HT = 672;
  localparam int unsigned VT = 301;
  localparam int unsigned T_FRAME0 = 45 * HT;   // tick index of (0,0) after reset

  typedef struct packed {
    logic        rd_en;
    logic [12:0] addr;
    logic        pixel;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } obs_t;

  localparam obs_t RST_OBS = {1'b0, 13'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset, pix_ce;
  logic pixel, de, hsync, vsync, frame_start;

  screen_scanout_if rd_if ();

  screen_scanout #(
    .H_FRONT  (16),
    .H_SYNC   (96),
    .H_BACK   (48),
    .V_FRONT  (10),
    .V_SYNC   (2),
    .V_BACK   (33),
    .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .rd          (rd_if),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [SCREEN_WORDS];

  // Synchronous RAM: data one clk after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (rd_if.rd_en) rd_if.rd_data <= mem[rd_if.rd_addr];
    else             rd_if.rd_data <= 16'($urandom);
  end

  int   checks = 0;
  int   failures = 0;
  int unsigned t;        // ticks processed since reset
  obs_t exp_o;           // expected outputs, held between ticks

  // Reference: outputs after the tick at index t, from raster arithmetic.
  function automatic obs_t model(input int unsigned tk, input logic [12:0] prev_addr);
    obs_t        e;
    int unsigned h, v;
    logic [15:0] w;
    h = tk % HT;
    v = (256 + tk / HT) % VT;
    e.de = (h < 512) && (v < 256);
    e.hs = !((h >= 528) && (h < 624));
    e.vs = !((v >= 266) && (v < 268));
    e.fs = (h == 0) && (v == 0);
    e.pixel = 1'b0;
    if (e.de) begin
      w = mem[v * 32 + h / 16];
      e.pixel = w[h % 16];
    end
    e.rd_en = 1'b0;
    e.addr  = prev_addr;
    if (v < 256 && h % 16 == 14 && h < 496) begin
      e.rd_en = 1'b1;
      e.addr  = 13'(v * 32 + (h + 2) / 16);
    end else if (h == HT - 2 && v < 255) begin
      e.rd_en = 1'b1;
      e.addr  = 13'((v + 1) * 32);
    end else if (h == HT - 2 && v == VT - 1) begin
      e.rd_en = 1'b1;
      e.addr  = 13'd0;
    end
    return e;
  endfunction

  function automatic obs_t observe();
    return {rd_if.rd_en, rd_if.rd_addr, pixel, de, hsync, vsync, frame_start};
  endfunction

  task automatic test_reset();
    obs_t o;
    reset  = 1'b1;
    pix_ce = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      pix_ce = 1'($urandom);
      o = observe();
      checks++;
      if (o !== RST_OBS) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got=%h want=%h", i, o, RST_OBS);
      end
    end
    reset = 1'b0;
    t     = 0;
    exp_o = RST_OBS;
  endtask

  task automatic test_frame_ce1();
    obs_t        o;
    int          first_rd = -1;
    int          blank_rd = 0;
    int          de_line0 = 0;
    logic [31:0] line0_px = '0;
    for (int n = 0; n < int'(T_FRAME0 + 6 * HT); n++) begin
      pix_ce = 1'b1;
      @(posedge clk); @(negedge clk);
      exp_o = model(t, exp_o.addr);
      o = observe();
      checks++;
      if (o !== exp_o) begin
        failures++;
        $display("FAIL ce1_stream t=%0d h=%0d v=%0d got=%h want=%h",
                 t, t % HT, (256 + t / HT) % VT, o, exp_o);
      end
      if (o.rd_en && first_rd < 0) first_rd = n;
      if (o.rd_en && n < int'(44 * HT)) blank_rd++;
      if (o.de && n >= int'(T_FRAME0) && n < int'(T_FRAME0 + HT)) de_line0++;
      if (n >= int'(T_FRAME0) && n < int'(T_FRAME0 + 32)) line0_px[n - int'(T_FRAME0)] = o.pixel;
      t++;
    end
    checks++;
    if (first_rd != int'(44 * HT + 670)) begin
      failures++;
      $display("FAIL first_rd_tick got=%0d want=%0d", first_rd, 44 * HT + 670);
    end
    checks++;
    if (blank_rd != 0) begin
      failures++;
      $display("FAIL blank_line_reads got=%0d want=0", blank_rd);
    end
    checks++;
    if (de_line0 != 512) begin
      failures++;
      $display("FAIL de_per_line got=%0d want=512", de_line0);
    end
    checks++;
    if (line0_px !== 32'h8000_0001) begin
      failures++;
      $display("FAIL line0_words01 got=%h want=%h", line0_px, 32'h8000_0001);
    end
  endtask

  // Reset issued right after a fetch, so the RAM return lands in the clk after reset.
  task automatic test_reset_midline();
    obs_t o;
    for (int n = 0; n < 303; n++) begin
      pix_ce = 1'b1;
      @(posedge clk); @(negedge clk);
      exp_o = model(t, exp_o.addr);
      o = observe();
      checks++;
      if (o !== exp_o) begin
        failures++;
        $display("FAIL pre_reset t=%0d got=%h want=%h", t, o, exp_o);
      end
      t++;
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    o = observe();
    checks++;
    if (o !== RST_OBS) begin
      failures++;
      $display("FAIL midline_reset got=%h want=%h", o, RST_OBS);
    end
    reset  = 1'b0;
    pix_ce = 1'b0;
    @(posedge clk); @(negedge clk);
    o = observe();
    checks++;
    if (o !== RST_OBS) begin
      failures++;
      $display("FAIL frozen_after_reset got=%h want=%h", o, RST_OBS);
    end
    t     = 0;
    exp_o = RST_OBS;
  endtask

  // Same raster as the pix_ce=1 run; active rows 0..2 ticked once every 4 clks.
  task automatic test_ce_quarter();
    obs_t o;
    logic ce;
    int   c = 0;
    while (t < T_FRAME0 + 3 * HT) begin
      ce = (t < T_FRAME0 - 8) ? 1'b1 : (c % 4 == 0);
      pix_ce = ce;
      @(posedge clk); @(negedge clk);
      if (ce) begin
        exp_o = model(t, exp_o.addr);
        t++;
      end else begin
        exp_o.rd_en = 1'b0;
        exp_o.fs    = 1'b0;
      end
      o = observe();
      checks++;
      if (o !== exp_o) begin
        failures++;
        $display("FAIL ce_quarter t=%0d ce=%0d got=%h want=%h", t, ce, o, exp_o);
      end
      c++;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(SCREEN_WORDS); i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
    reset  = 1'b1;
    pix_ce = 1'b0;
    test_reset();
    test_frame_ce1();
    test_reset_midline();
    test_ce_quarter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
